frame_tx_arbiter: RTL
=====================

Name: frame_tx_arbiter

Overview:
- Frame-level scheduler sharing one TX MAC byte stream between two ingress frame FIFOs: bridge-forwarded traffic (src 0) and local/management traffic (src 1).
- Per source, takes a frame descriptor (valid + length), pops exactly that many bytes from the source FIFO, and streams them as one frame with a valid/ready/last handshake.
- Inserts a fixed inter-frame gap after each frame.
- Sits between the per-port fifo_buff instances and the TX MAC.

Parameters:
- DATA_W, 8, byte-lane width; must match source FIFO width.
- LEN_W, 11, width of frame length fields (max 2047 bytes).
- IFG_CYCLES, 12, idle cycles enforced after each tx_last beat; 0 means no gap.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- src_frm_valid  in  2  per source: a complete frame descriptor is pending.
- src_frm_len  in  2*LEN_W  per source: byte length of the pending frame; [LEN_W-1:0] is src 0.
- src_frm_ack  out  2  one-cycle pulse: descriptor consumed.
- src_rd  out  2  FIFO read strobe; data appears on src_data the next cycle.
- src_data  in  2*DATA_W  FIFO data_out per source.
- src_empty  in  2  FIFO empty flag per source.
- tx_data  out  DATA_W  byte to MAC.
- tx_valid  out  1  tx_data valid.
- tx_last  out  1  final byte of frame, qualified by tx_valid.
- tx_ready  in  1  MAC accepts the beat when tx_valid and tx_ready are both high.
- busy  out  1  high in any state other than IDLE.
- grant  out  1  index of the source currently owning the stream.

Behaviour:
- Reset values: src_frm_ack=0, src_rd=0, tx_valid=0, tx_last=0, tx_data=0, busy=0, grant=0, round-robin pointer=0 (src 0 preferred first). Reset mid-frame abandons the frame immediately; no tx_last is emitted.
- FSM states: IDLE, GRANT, STREAM, GAP.
- IDLE: if any src_frm_valid is set, go to GRANT.
- Round-robin choice: pick the requester at the pointer if it is valid, otherwise the other one.
  - Latch grant and the length into remaining (LEN_W bits).
  - Pulse src_frm_ack[grant] for one cycle.
  - After each granted frame, the pointer moves to the other source.
- GRANT:
  - Length 0: frame is dropped. Ack only, no beats, no gap, return to IDLE.
  - Otherwise go to STREAM.
- STREAM, read side:
  - Assert src_rd[grant] when all hold: remaining>0, src_empty[grant]=0, and (outstanding reads + skid occupancy) < 2.
  - Each read decrements remaining.
  - Returned data enters a 2-entry skid buffer one cycle after src_rd.
- STREAM, output side:
  - tx_valid = skid not empty; tx_data = skid head.
  - tx_last = head is the final byte (remaining==0, no reads outstanding, skid occupancy==1).
  - Outputs hold stable while tx_valid=1 and tx_ready=0.
  - Full throughput: 1 byte/cycle while tx_ready=1 and the FIFO stays non-empty.
  - Latency: first tx_valid 2 cycles after GRANT.
- FIFO underrun mid-frame (src_empty=1 before remaining==0): reads stall and tx_valid drops once the skid drains. The frame resumes when data arrives; no bytes are skipped or duplicated.
- GAP:
  - Entered on the tx_last handshake.
  - Counts IFG_CYCLES cycles with tx_valid=0, then returns to IDLE.
  - If IFG_CYCLES=0, go straight to IDLE.
  - Requests arriving during GAP wait.
- Simultaneous requests in IDLE: resolved by the pointer. A descriptor changing while not acked is sampled only at the ack cycle.
- Never asserts src_rd on a non-granted source. Never issues more reads than the latched length.

Optional Feature:
- Macro ARB_STRICT_PRIO_EN.
- Defined: src 0 always wins when both sources are valid; the pointer is unused. src 1 can starve. An in-progress frame is never pre-empted.
- Undefined: round-robin as above.

Decomposition:
- Shared package frame_tx_pkg holds:
  - state enum (IDLE/GRANT/STREAM/GAP, 2-bit encoding);
  - default LEN_W, DATA_W;
  - constant ETH_IFG_BYTES=12.
- One natural sub-module: tx_skid_buf, a 2-entry valid/ready skid buffer with an occupancy output.
- Arbitration and the FSM stay in the top module.

Test Plan:
- Src 0 only, len=64, FIFO preloaded, tx_ready=1 → 64 consecutive beats matching FIFO order, tx_last on beat 64, src_frm_ack pulses once, then 12 idle cycles.
- Both sources valid in IDLE with len 10 and 20, held valid → frames granted 0,1,0,1 alternately. With ARB_STRICT_PRIO_EN defined → 0,0,0 while src 0 remains valid.
- len=32, tx_ready toggled 1/0 every cycle → exactly 32 accepted beats with correct data, tx_data stable across stalls, src_rd never leaves >2 bytes outstanding.
- len=16, src_empty forced high after byte 5 for 7 cycles → tx_valid gap, then bytes 6-16 in order, tx_last on byte 16, total src_rd count exactly 16.
- len=0 descriptor on src 1 → ack pulse, no tx_valid, no GAP. The next src 0 frame starts immediately after.
- rst asserted mid-frame at byte 7 of 40 → all outputs return to reset values asynchronously. After release the FSM is in IDLE and accepts a new descriptor normally.

Source files
------------

// File: rtl/frame_tx_pkg.sv
// frame_tx_pkg
// Shared definitions for the TX frame arbiter: FSM state encoding, default
// datapath widths and the standard Ethernet inter-frame gap in byte times.
package frame_tx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    STREAM = 2'd2,
    GAP    = 2'd3
  } state_t;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_LEN_W     = 11;
  localparam int ETH_IFG_BYTES = 12;

endpackage

// File: rtl/tx_skid_buf.sv
// tx_skid_buf
// Two-entry FIFO-style skid buffer between the source FIFO read pipeline and
// the MAC handshake. The producer side has no ready: the caller meters pushes
// with the occupancy output so that a push never lands on a full buffer.
// Ports:
//   clk, rst      clock, asynchronous active-high reset (control state only)
//   in_valid      push strobe
//   in_data       pushed byte
//   out_valid     head entry present
//   out_data      head entry
//   out_ready     consumer takes the head when out_valid is also high
//   occ           number of stored entries (0..2)
module tx_skid_buf #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [1:0]        occ
);

  logic [DATA_W-1:0] mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic              push;
  logic              pop;

  // A push while full is discarded rather than overwriting the head.
  assign push      = in_valid && (occ != 2'd2);
  assign pop       = out_valid && out_ready;
  assign out_valid = (occ != 2'd0);
  assign out_data  = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: rtl/frame_tx_arbiter.sv
// frame_tx_arbiter
// Frame-level scheduler that shares one TX MAC byte stream between two
// ingress frame FIFOs (src 0: bridge-forwarded, src 1: local/management).
// A descriptor (valid + length) is acknowledged, exactly that many bytes are
// popped from the granted FIFO and streamed with valid/ready/last, and a
// fixed inter-frame gap follows every frame.
// Build option: define ARB_STRICT_PRIO_EN to give src 0 absolute priority
// (src 1 may starve); otherwise sources alternate round-robin per frame.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   src_frm_valid   per-source descriptor pending
//   src_frm_len     per-source frame length, src 0 in the low LEN_W bits
//   src_frm_ack     one-cycle descriptor-consumed pulse
//   src_rd          FIFO read strobe, data returns the next cycle
//   src_data        FIFO data per source, src 0 in the low DATA_W bits
//   src_empty       FIFO empty flag per source
//   tx_data/tx_valid/tx_last/tx_ready   byte stream to the MAC
//   busy            FSM is outside IDLE
//   grant           source owning the stream
module frame_tx_arbiter
  import frame_tx_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int LEN_W      = DEF_LEN_W,
  parameter int IFG_CYCLES = ETH_IFG_BYTES
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          src_frm_valid,
  input  logic [2*LEN_W-1:0]  src_frm_len,
  output logic [1:0]          src_frm_ack,
  output logic [1:0]          src_rd,
  input  logic [2*DATA_W-1:0] src_data,
  input  logic [1:0]          src_empty,
  output logic [DATA_W-1:0]   tx_data,
  output logic                tx_valid,
  output logic                tx_last,
  input  logic                tx_ready,
  output logic                busy,
  output logic                grant
);

  localparam int GAP_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

  state_t            state;
  logic [LEN_W-1:0]  remaining;
  logic [GAP_W-1:0]  gap_cnt;
  logic              rd_vld_p1;
  logic              sel;
  logic [LEN_W-1:0]  sel_len;
  logic              rd_en;
  logic              credit_ok;
  logic              tx_fire;
  logic              skid_vld;
  logic [1:0]        skid_occ;
  logic [DATA_W-1:0] skid_data;
  logic [DATA_W-1:0] fifo_data;

`ifndef ARB_STRICT_PRIO_EN
  logic              rr_ptr;
`endif

  // Source selection, only acted upon in IDLE.
  always_comb begin
`ifdef ARB_STRICT_PRIO_EN
    sel = src_frm_valid[0] ? 1'b0 : 1'b1;
`else
    sel = src_frm_valid[rr_ptr] ? rr_ptr : ~rr_ptr;
`endif
    sel_len = sel ? src_frm_len[2*LEN_W-1:LEN_W] : src_frm_len[LEN_W-1:0];
  end

  assign tx_fire   = tx_valid && tx_ready;
  assign fifo_data = grant ? src_data[2*DATA_W-1:DATA_W] : src_data[DATA_W-1:0];

  // Bytes in flight plus bytes buffered may not exceed the two skid slots.
  // A beat leaving this cycle frees a slot, which keeps 1 byte/cycle going.
  assign credit_ok = ({1'b0, skid_occ} + {2'b00, rd_vld_p1}) < (3'd2 + {2'b00, tx_fire});

  // Reading starts already in GRANT so the first beat appears two cycles later.
  assign rd_en  = ((state == GRANT) || (state == STREAM)) && (remaining != '0) &&
                  !src_empty[grant] && credit_ok;
  assign src_rd = grant ? {rd_en, 1'b0} : {1'b0, rd_en};

  // Stage p1: FIFO data returns one cycle after the read strobe.
  tx_skid_buf #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd_vld_p1),
    .in_data   (fifo_data),
    .out_valid (skid_vld),
    .out_data  (skid_data),
    .out_ready (tx_ready),
    .occ       (skid_occ)
  );

  // Stage p2: skid head drives the MAC.
  assign tx_valid = skid_vld;
  assign tx_data  = skid_vld ? skid_data : '0;
  assign tx_last  = skid_vld && (state == STREAM) && (remaining == '0) &&
                    !rd_vld_p1 && (skid_occ == 2'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= 1'b0;
      src_frm_ack <= 2'b00;
      busy        <= 1'b0;
      remaining   <= '0;
      gap_cnt     <= '0;
      rd_vld_p1   <= 1'b0;
`ifndef ARB_STRICT_PRIO_EN
      rr_ptr      <= 1'b0;
`endif
    end else begin
      src_frm_ack <= 2'b00;
      rd_vld_p1   <= rd_en;
      if (rd_en) remaining <= remaining - LEN_W'(1);

      case (state)
        IDLE: begin
          if (|src_frm_valid) begin
            grant       <= sel;
            remaining   <= sel_len;
            src_frm_ack <= sel ? 2'b10 : 2'b01;
`ifndef ARB_STRICT_PRIO_EN
            rr_ptr      <= ~sel;
`endif
            busy        <= 1'b1;
            state       <= GRANT;
          end
        end
        GRANT: begin
          // Zero-length descriptors are dropped: acked, no beats, no gap.
          if (remaining == '0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            state <= STREAM;
          end
        end
        STREAM: begin
          if (tx_last && tx_ready) begin
            if (IFG_CYCLES == 0) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              gap_cnt <= GAP_W'(IFG_CYCLES - 1);
              state   <= GAP;
            end
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
